// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode/operand stage of the 5-stage MIPS pipeline.
// Holds one instruction in a decode register and reads the regfile.
// Picks forwarded operands from NUM_FWD sources, applies the load-use
// interlock, resolves branches, and feeds a registered ID/EX slot.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid & ready are both high. A producer holding valid keeps its payload
// stable until the transfer. ready never depends on the same port's valid.
// in_ready = decode register empty or its instruction leaves this cycle.
// The ID/EX slot keeps its contents while out_valid & !out_ready.
module id_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_W-1:0]                   in_pc,
    input  logic [31:0]                         in_inst,
    output logic [RF_AW-1:0]                    rf_raddr1,
    output logic [RF_AW-1:0]                    rf_raddr2,
    input  logic [DATA_W-1:0]                   rf_rdata1,
    input  logic [DATA_W-1:0]                   rf_rdata2,
    input  logic [NUM_FWD*(2+RF_AW+DATA_W)-1:0] fwd_bus,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_W-1:0]                   out_pc,
    output logic [31:0]                         out_inst,
    output logic [DATA_W-1:0]                   out_src1,
    output logic [DATA_W-1:0]                   out_src2,
    output logic                                br_valid,
    output logic [DATA_W-1:0]                   br_addr,
    output logic                                stallreq,
    output logic [CNT_W-1:0]                    stall_cnt
);

    localparam int SRC_W = 2 + RF_AW + DATA_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // State: decode register, ID/EX slot, interlock counter
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] d_pc_q, d_pc_d;
    logic [31:0]       d_inst_q, d_inst_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [DATA_W-1:0] out_src1_q, out_src1_d;
    logic [DATA_W-1:0] out_src2_q, out_src2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Unpacked forwarding sources
    logic              fwd_we    [NUM_FWD];
    logic              fwd_pend  [NUM_FWD];
    logic [RF_AW-1:0]  fwd_waddr [NUM_FWD];
    logic [DATA_W-1:0] fwd_wdata [NUM_FWD];

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       index;
    logic [RF_AW-1:0]  rs_addr;
    logic [RF_AW-1:0]  rt_addr;
    logic [DATA_W-1:0] src1, src2;
    logic              pend1, pend2;
    logic              rs_used, rt_used;
    logic              hazard;
    logic              d_fire;
    logic              in_load;
    logic              taken;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] br_off;

    assign opcode  = d_inst_q[31:26];
    assign funct   = d_inst_q[5:0];
    assign imm     = d_inst_q[15:0];
    assign index   = d_inst_q[25:0];
    assign rs_addr = RF_AW'(d_inst_q[25:21]);
    assign rt_addr = RF_AW'(d_inst_q[20:16]);

    // Split the flat forwarding bus into per-source fields {we, pend, waddr, wdata}
    always_comb begin
        for (int i = 0; i < NUM_FWD; i++) begin
            fwd_wdata[i] = fwd_bus[i*SRC_W +: DATA_W];
            fwd_waddr[i] = fwd_bus[i*SRC_W + DATA_W +: RF_AW];
            fwd_pend[i]  = fwd_bus[i*SRC_W + DATA_W + RF_AW];
            fwd_we[i]    = fwd_bus[i*SRC_W + DATA_W + RF_AW + 1];
        end
    end

    // Operand select: r0 is zero, else lowest-index writing source, else regfile.
    // The winner's pend bit travels with the value so a shadowed pend is ignored.
    always_comb begin
        src1  = rf_rdata1;
        pend1 = 1'b0;
        src2  = rf_rdata2;
        pend2 = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i] == rs_addr)) begin
                src1  = fwd_wdata[i];
                pend1 = fwd_pend[i];
            end
            if (fwd_we[i] && (fwd_waddr[i] == rt_addr)) begin
                src2  = fwd_wdata[i];
                pend2 = fwd_pend[i];
            end
        end
        if (rs_addr == '0) begin
            src1  = '0;
            pend1 = 1'b0;
        end
        if (rt_addr == '0) begin
            src2  = '0;
            pend2 = 1'b0;
        end
    end

    // Register usage flags, interlock and handshake
    always_comb begin
        rs_used  = !((opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_LUI));
        rt_used  = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                   (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
        hazard   = d_valid_q && ((rs_used && pend1) || (rt_used && pend2));
        d_fire   = d_valid_q && !hazard && (!out_valid_q || out_ready);
        in_ready = !d_valid_q || d_fire;
        in_load  = in_valid && in_ready;
    end

    // Branch resolution with the forwarded operands; the delay slot is never killed
    always_comb begin
        pc4    = d_pc_q + {{(DATA_W-3){1'b0}}, 3'd4};
        br_off = {{(DATA_W-18){imm[15]}}, imm, 2'b00};
        taken  = 1'b0;
        target = '0;
        case (opcode)
            OP_BEQ: begin
                taken  = (src1 == src2);
                target = pc4 + br_off;
            end
            OP_BNE: begin
                taken  = (src1 != src2);
                target = pc4 + br_off;
            end
            OP_J, OP_JAL: begin
                taken         = 1'b1;
                target        = pc4;
                target[27:0]  = {index, 2'b00};
            end
            OP_RTYPE: begin
                if ((funct == FN_JR) || (funct == FN_JALR)) begin
                    taken  = 1'b1;
                    target = src1;
                end
            end
            default: begin
                taken  = 1'b0;
                target = '0;
            end
        endcase
        br_valid = d_fire && taken;
        br_addr  = br_valid ? target : '0;
    end

    // Next state: flush beats every load; the slot drains when EX takes it and nothing replaces it
    always_comb begin
        d_valid_d   = d_valid_q;
        d_pc_d      = d_pc_q;
        d_inst_d    = d_inst_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_src1_d  = out_src1_q;
        out_src2_d  = out_src2_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            d_valid_d   = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (in_load) begin
                d_valid_d = 1'b1;
                d_pc_d    = in_pc;
                d_inst_d  = in_inst;
            end else if (d_fire) begin
                d_valid_d = 1'b0;
            end

            if (d_fire) begin
                out_valid_d = 1'b1;
                out_pc_d    = d_pc_q;
                out_inst_d  = d_inst_q;
                out_src1_d  = src1;
                out_src2_d  = src2;
            end else if (out_ready && out_valid_q) begin
                out_valid_d = 1'b0;
            end
        end

        if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid_q   <= 1'b0;
            d_pc_q      <= '0;
            d_inst_q    <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_src1_q  <= '0;
            out_src2_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_pc_q      <= d_pc_d;
            d_inst_q    <= d_inst_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_src1_q  <= out_src1_d;
            out_src2_q  <= out_src2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_raddr1 = rs_addr;
    assign rf_raddr2 = rt_addr;
    assign stallreq  = hazard;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign out_src1  = out_src1_q;
    assign out_src2  = out_src2_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: regfile model, forwarding-source drivers, and an
// expected queue of ID/EX slot contents popped whenever EX consumes the slot.
module tb_id_fwd_stage;

    localparam int DATA_W  = 32;
    localparam int RF_AW   = 5;
    localparam int NUM_FWD = 3;
    localparam int CNT_W   = 16;
    localparam int SRC_W   = 2 + RF_AW + DATA_W;
    localparam int W       = 128;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_pc;
    logic [31:0]                in_inst;
    logic [RF_AW-1:0]           rf_raddr1, rf_raddr2;
    logic [DATA_W-1:0]          rf_rdata1, rf_rdata2;
    logic [NUM_FWD*SRC_W-1:0]   fwd_bus;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_pc;
    logic [31:0]                out_inst;
    logic [DATA_W-1:0]          out_src1, out_src2;
    logic                       br_valid;
    logic [DATA_W-1:0]          br_addr;
    logic                       stallreq;
    logic [CNT_W-1:0]           stall_cnt;

    logic                       fwd_we    [NUM_FWD];
    logic                       fwd_pend  [NUM_FWD];
    logic [RF_AW-1:0]           fwd_waddr [NUM_FWD];
    logic [DATA_W-1:0]          fwd_wdata [NUM_FWD];
    logic [DATA_W-1:0]          rf        [32];

    logic [W-1:0]               exp_q[$];
    logic [W-1:0]               exp_e;
    int                         checks;
    int                         failures;

    id_fwd_stage #(
        .DATA_W(DATA_W), .RF_AW(RF_AW), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_bus(fwd_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_src1(out_src1), .out_src2(out_src2),
        .br_valid(br_valid), .br_addr(br_addr),
        .stallreq(stallreq), .stall_cnt(stall_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always_comb begin
        fwd_bus = '0;
        for (int i = 0; i < NUM_FWD; i++)
            fwd_bus[i*SRC_W +: SRC_W] = {fwd_we[i], fwd_pend[i], fwd_waddr[i], fwd_wdata[i]};
    end

    // Scoreboard: a slot transfer happens at the next posedge when valid & ready
    always @(negedge clk) begin
        if (rst && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got pc=%h inst=%h with no expected entry", out_pc, out_inst);
            end else begin
                exp_e = exp_q.pop_front();
                if ({out_pc, out_inst, out_src1, out_src2} !== exp_e) begin
                    failures++;
                    $display("FAIL sb_out got=%h exp=%h", {out_pc, out_inst, out_src1, out_src2}, exp_e);
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NUM_FWD; i++) begin
            fwd_we[i] = 1'b0; fwd_pend[i] = 1'b0; fwd_waddr[i] = '0; fwd_wdata[i] = '0;
        end
    endtask

    task automatic set_fwd(input int i, input logic we, input logic pend,
                           input logic [RF_AW-1:0] addr, input logic [DATA_W-1:0] data);
        fwd_we[i] = we; fwd_pend[i] = pend; fwd_waddr[i] = addr; fwd_wdata[i] = data;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    endtask

    function automatic logic [31:0] make_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, br_valid, stallreq} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl got in_ready/out_valid/br_valid/stallreq=%b exp=1000",
                     {in_ready, out_valid, br_valid, stallreq});
        end
        checks++;
        if ({out_pc, out_inst, out_src1, out_src2, br_addr, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_data got pc=%h inst=%h s1=%h s2=%h ba=%h cnt=%h exp all 0",
                     out_pc, out_inst, out_src1, out_src2, br_addr, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_stream();
        rf[1] = 32'd5; rf[2] = 32'd7;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h40 + 32'(4 * k);
            in_inst  = make_r(5'd1, 5'd2, 5'd3, FN_ADDU);
            exp_q.push_back({in_pc, in_inst, 32'd5, 32'd7});
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready);
            end
            if (k >= 1) begin
                checks++;
                if (out_valid !== (k >= 2)) begin
                    failures++; $display("FAIL stream_out_valid k=%0d got=%b exp=%b", k, out_valid, k >= 2);
                end
            end
            step();
        end
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL stream_drain got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_priority();
        logic [31:0] inst;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clear_fwd();
            case (k)
                0: begin
                    set_fwd(0, 1'b1, 1'b0, 5'd1, 32'hA); set_fwd(2, 1'b1, 1'b0, 5'd1, 32'hC);
                    inst = make_r(5'd1, 5'd2, 5'd3, FN_ADDU);
                    exp_q.push_back({32'h80, inst, 32'hA, 32'd7});
                end
                1: begin
                    set_fwd(0, 1'b1, 1'b0, 5'd0, 32'hA); set_fwd(2, 1'b1, 1'b0, 5'd0, 32'hC);
                    inst = make_r(5'd0, 5'd2, 5'd3, FN_ADDU);
                    exp_q.push_back({32'h80, inst, 32'h0, 32'd7});
                end
                default: begin
                    set_fwd(0, 1'b1, 1'b0, 5'd2, 32'hB); set_fwd(1, 1'b1, 1'b1, 5'd2, 32'hD);
                    inst = make_r(5'd1, 5'd2, 5'd3, FN_ADDU);
                    exp_q.push_back({32'h80, inst, 32'd5, 32'hB});
                end
            endcase
            in_valid = 1'b1; in_pc = 32'h80; in_inst = inst;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (stallreq !== 1'b0) begin
                failures++; $display("FAIL prio_no_stall k=%0d got=%b exp=0", k, stallreq);
            end
            step();
            wait_drain();
        end
        clear_fwd();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL prio_drain got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_load_use();
        logic [31:0] inst;
        out_ready = 1'b1;
        set_fwd(0, 1'b1, 1'b1, 5'd4, 32'h99);
        inst = make_r(5'd4, 5'd0, 5'd5, FN_ADDU);
        in_valid = 1'b1; in_pc = 32'hC0; in_inst = inst;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({stallreq, in_ready, out_valid} !== 3'b100 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL lu_stall got stallreq/in_ready/out_valid=%b cnt=%0d exp=100 cnt=0",
                     {stallreq, in_ready, out_valid}, stall_cnt);
        end
        step();
        clear_fwd();
        set_fwd(1, 1'b1, 1'b0, 5'd4, 32'h55);
        exp_q.push_back({32'hC0, inst, 32'h55, 32'h0});
        @(negedge clk);
        checks++;
        if ({stallreq, in_ready} !== 2'b01 || stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL lu_release got stallreq/in_ready=%b cnt=%0d exp=01 cnt=1",
                     {stallreq, in_ready}, stall_cnt);
        end
        step();
        clear_fwd();
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL lu_drain got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_branch();
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exp_bv;
        logic [31:0] exp_ba;
        logic [31:0] s1, s2;
        out_ready = 1'b1;
        clear_fwd();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin rf[1] = 32'd9; rf[2] = 32'd9; pc = 32'h100;
                         inst = {OP_BEQ, 5'd1, 5'd2, 16'd3}; exp_bv = 1'b1; exp_ba = 32'h110;
                         s1 = 32'd9; s2 = 32'd9; end
                1: begin rf[2] = 32'd8; pc = 32'h100;
                         inst = {OP_BEQ, 5'd1, 5'd2, 16'd3}; exp_bv = 1'b0; exp_ba = 32'h0;
                         s1 = 32'd9; s2 = 32'd8; end
                2: begin rf[31] = 32'h2000; pc = 32'h200;
                         inst = make_r(5'd31, 5'd0, 5'd0, FN_JR); exp_bv = 1'b1; exp_ba = 32'h2000;
                         s1 = 32'h2000; s2 = 32'h0; end
                default: begin pc = 32'h3000_0100;
                         inst = {OP_J, 26'h40}; exp_bv = 1'b1; exp_ba = 32'h3000_0100;
                         s1 = 32'h0; s2 = 32'h0; end
            endcase
            in_valid = 1'b1; in_pc = pc; in_inst = inst;
            exp_q.push_back({pc, inst, s1, s2});
            step();
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (br_valid !== exp_bv || br_addr !== exp_ba) begin
                failures++;
                $display("FAIL branch k=%0d got bv=%b ba=%h exp bv=%b ba=%h", k, br_valid, br_addr, exp_bv, exp_ba);
            end
            step();
            wait_drain();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL branch_drain got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        rf[1] = $urandom; rf[2] = $urandom;
        a = rf[1]; b = rf[2];
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h200; in_inst = make_r(5'd1, 5'd2, 5'd3, FN_ADDU);
        exp_q.push_back({in_pc, in_inst, a, b});
        step();
        in_pc = 32'h204; in_inst = make_r(5'd2, 5'd1, 5'd4, FN_ADDU);
        exp_q.push_back({in_pc, in_inst, b, a});
        step();
        in_pc = 32'h208; in_inst = make_r(5'd1, 5'd1, 5'd6, FN_ADDU);
        exp_q.push_back({in_pc, in_inst, a, a});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_src1 !== a) begin
                failures++;
                $display("FAIL bp_hold c=%0d got in_ready=%b ov=%b pc=%h s1=%h exp 0 1 200 %h",
                         c, in_ready, out_valid, out_pc, out_src1, a);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got in_ready=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL bp_drain got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h300; in_inst = make_r(5'd1, 5'd2, 5'd3, FN_ADDU);
        step();
        flush = 1'b1; in_pc = 32'h304;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, stallreq} !== 3'b010 || stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL flush_kill got ov/in_ready/stallreq=%b cnt=%0d exp=010 cnt=1",
                     {out_valid, in_ready, stallreq}, stall_cnt);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_after got ov=%b exp=0", out_valid);
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        clear_fwd();
        set_fwd(0, 1'b1, 1'b1, 5'd4, 32'h77);
        in_valid = 1'b1; in_pc = 32'h400; in_inst = make_r(5'd1, 5'd2, 5'd3, FN_ADDU);
        step();
        in_pc = 32'h404; in_inst = make_r(5'd4, 5'd0, 5'd5, FN_ADDU);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (stallreq !== 1'b1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre got stallreq=%b ov=%b exp 1 1", stallreq, out_valid);
        end
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({in_ready, out_valid, br_valid, stallreq} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_ctrl got in_ready/ov/bv/stallreq=%b exp=1000",
                     {in_ready, out_valid, br_valid, stallreq});
        end
        checks++;
        if ({out_pc, out_inst, out_src1, out_src2, br_addr, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL rst_mid_data got pc=%h inst=%h s1=%h s2=%h ba=%h cnt=%h exp all 0",
                     out_pc, out_inst, out_src1, out_src2, br_addr, stall_cnt);
        end
        @(negedge clk);
        clear_fwd();
        rst = 1'b1;
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_after got ov=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        step();
    endtask

    // Test sequence and final report
    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        clear_fwd();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #1 rst = 1'b0;
        test_reset();
        test_stream();
        test_priority();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL final_queue got pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Parametrised decode/operand stage for the 5-stage MIPS pipeline. It generalises the single-register ID stage in three ways: valid/ready handshakes replace the global stall bus, forwarding takes a configurable number of sources, and a load-use interlock replaces stall-free forwarding. The stage sits between IF and EX. It holds one instruction in a decode register, reads the external regfile, resolves branches, and drives a registered ID/EX output slot.

## Interface
- DATA_W, 32, datapath and PC width
- RF_AW, 5, register address width
- NUM_FWD, 3, forwarding sources; index 0 highest priority (EX), then MEM, WB
- CNT_W, 16, stall counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- flush  in  1  synchronous kill of both held instructions
- in_valid  in  1  IF offers an instruction
- in_ready  out  1  stage accepts the IF instruction this cycle
- in_pc  in  DATA_W  PC of the offered instruction
- in_inst  in  32  offered instruction
- rf_raddr1, rf_raddr2  out  RF_AW  regfile read addresses (rs, rt of decode register)
- rf_rdata1, rf_rdata2  in  DATA_W  combinational regfile read data
- fwd_bus  in  NUM_FWD*(2+RF_AW+DATA_W)  per source {we, pend, waddr, wdata}; source i occupies slice i
- out_valid  out  1  ID/EX slot holds an instruction
- out_ready  in  1  EX consumes the slot
- out_pc, out_inst  out  DATA_W, 32  registered PC and instruction
- out_src1, out_src2  out  DATA_W  registered forwarded rs and rt operands
- br_valid  out  1  branch/jump taken; combinational; valid only in a decode-fire cycle
- br_addr  out  DATA_W  branch target
- stallreq  out  1  interlock active
- stall_cnt  out  CNT_W  saturating count of interlock cycles

## Operation
- Decode register: d_valid, d_pc, d_inst. Loads on in_valid & in_ready. Cleared when the instruction fires with no new load.
- Operand select, per rs and rt:
  - Address 0 always yields 0.
  - Otherwise take the lowest index i with we_i & waddr_i == addr.
  - If no source matches, take rf_rdata.
- Usage flags:
  - rs_used = !(j | jal | lui).
  - rt_used = R-type | beq | bne | sb | sh | sw.
- hazard = d_valid & ((rs_used & pend of rs winner) | (rt_used & pend of rt winner)). A pend bit on a lower-priority match that is shadowed by a non-pend higher-priority match does not cause a hazard.
- d_fire = d_valid & !hazard & (!out_valid | out_ready).
- in_ready = !d_valid | d_fire.
- On d_fire the output slot loads pc, inst and the forwarded operands, and out_valid is set.
- If out_ready & out_valid & !d_fire, out_valid clears.
- Branches, resolved in ID using forwarded operands; pc4 = d_pc + 4:
  - beq taken when src1 == src2; bne taken when src1 != src2. Target = pc4 + sign-extended offset << 2.
  - j and jal: target = {pc4[31:28], index, 2'b0}.
  - jr and jalr: target = src1.
  - br_valid = d_fire & taken. br_addr is 0 when br_valid is low.
  - Delay slot is architectural; the stage never kills the next instruction on a branch.
- stallreq = hazard. stall_cnt increments every cycle stallreq is high and saturates at all-ones.
- flush: next edge clears d_valid and out_valid. A coincident input load is discarded. flush has priority over all loads. stall_cnt is unaffected.

## Timing
- Reset (asynchronous, rst = 0): d_valid = 0, out_valid = 0, and out_pc, out_inst, out_src1, out_src2 and stall_cnt are all 0.
- In reset: in_ready = 1, br_valid = 0, br_addr = 0, stallreq = 0.
- If reset is asserted mid-operation, both held instructions are lost immediately.
- Latency: an instruction accepted at edge N appears on out_* after edge N+1 when there is no hazard and no backpressure.
- Throughput is 1 per cycle.
- A load in EX (pend = 1) feeding a dependent instruction costs exactly 1 stall cycle when the producer moves to MEM with pend = 0.
- in_ready, stallreq, br_valid, br_addr and rf_raddr* are combinational from state and inputs. All out_* signals are registered.
- Full backpressure: out_valid = 1, out_ready = 0 and d_valid = 1 together give in_ready = 0. Nothing is overwritten.

## Test plan
- Reset then stream addu r3,r1,r2 ×4 with out_ready = 1 and rf_rdata1 = 5, rf_rdata2 = 7 -> in_ready held at 1; out_valid from cycle 2; out_src1 = 5, out_src2 = 7 each cycle.
- Priority: src0 {we=1, waddr=1, wdata=0xA} and src2 {we=1, waddr=1, wdata=0xC} -> out_src1 = 0xA. Repeat with waddr = 0 -> out_src1 = 0.
- Load-use: lw to r4 in src0 with pend = 1, decode holds addu r5,r4,r0 -> stallreq = 1 and in_ready = 0 for 1 cycle; stall_cnt goes 0 -> 1. Next cycle src1 {r4, 0x55, pend=0} -> out_src1 = 0x55.
- beq at d_pc = 0x100 with offset 3 and equal operands -> br_valid = 1, br_addr = 0x110. Same with unequal operands -> br_valid = 0. jr with r31 = 0x2000 -> br_addr = 0x2000.
- out_ready = 0 for 3 cycles with two instructions in flight -> out_* stable and in_ready = 0. Release -> both instructions emerge in order with no loss.
- flush coincident with in_valid -> next cycle out_valid = 0 and d_valid = 0. Drive rst low mid-stall -> all outputs at reset values immediately.
